// File: rtl/gf_muls_scl_pipe_pkg.sv
// GF(2^2) normal-basis [Omega^2, Omega] arithmetic shared by the Canright-style tower-field datapaths.
// Bit 1 of an element is the Omega^2 coefficient, bit 0 the Omega coefficient.
package gf_canright_pkg;

  typedef logic [1:0] gf2_t;

  localparam logic [1:0] MODE_MUL     = 2'd0;
  localparam logic [1:0] MODE_MUL_SCL = 2'd1;
  localparam logic [1:0] MODE_SQ      = 2'd2;
  localparam logic [1:0] MODE_SQ_SCL  = 2'd3;

  function automatic gf2_t gf2_mul(input gf2_t a, input gf2_t b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  // Scaling by N = Omega^2.
  function automatic gf2_t gf2_scl_n(input gf2_t x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  // Squaring in a normal basis is a coefficient swap.
  function automatic gf2_t gf2_sq(input gf2_t x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/gf_muls_scl_lane.sv
// Combinational single-lane GF(2^2) unit: multiply or square, optionally scaled by N.
module gf_muls_scl_lane
  import gf_canright_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] mode,
  output logic [1:0] q
);

  // Mode select over the four arithmetic results.
  always_comb begin
    q = 2'b00;
    case (mode)
      MODE_MUL:     q = gf2_mul(a, b);
      MODE_MUL_SCL: q = gf2_scl_n(gf2_mul(a, b));
      MODE_SQ:      q = gf2_sq(a);
      MODE_SQ_SCL:  q = gf2_scl_n(gf2_sq(a));
      default:      q = 2'b00;
    endcase
  end

endmodule

// File: rtl/gf_muls_scl_pipe.sv
// Multi-lane GF(2^2) arithmetic pipeline with global-stall valid/ready flow control.
// Bubbles travel with data; the whole pipe freezes when the last stage is held.
module gf_muls_scl_pipe
  import gf_canright_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_mode,
  input  logic [2*LANES-1:0]               in_a,
  input  logic [2*LANES-1:0]               in_b,
  input  logic [TAG_W-1:0]                 in_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2*LANES-1:0]               out_q,
  output logic [TAG_W-1:0]                 out_tag,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int W     = 2 * LANES;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [W-1:0]       res_s;
  logic               en_s;
  logic [STAGES-1:0]  vld_q, vld_d;
  logic [W-1:0]       data_q [STAGES];
  logic [W-1:0]       data_d [STAGES];
  logic [TAG_W-1:0]   tag_q  [STAGES];
  logic [TAG_W-1:0]   tag_d  [STAGES];
  logic [OCC_W-1:0]   occ_q, occ_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf_muls_scl_lane u_lane (
      .a    (in_a[2*i+1:2*i]),
      .b    (in_b[2*i+1:2*i]),
      .mode (in_mode),
      .q    (res_s[2*i+1:2*i])
    );
  end

  assign en_s     = ~vld_q[STAGES-1] | out_ready;
  assign in_ready = en_s;

  // Next-state of the shift pipeline; everything holds while stalled.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (en_s) begin
      vld_d[0]  = in_valid;
      data_d[0] = res_s;
      tag_d[0]  = in_tag;
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        data_d[s] = data_q[s-1];
        tag_d[s]  = tag_q[s-1];
      end
    end else begin
      vld_d  = vld_q;
      data_d = data_q;
      tag_d  = tag_q;
    end
  end

  // Occupancy is the popcount of the next valid vector so it can be registered.
  always_comb begin
    occ_d = {OCC_W{1'b0}};
    for (int s = 0; s < STAGES; s++) begin
      occ_d = occ_d + OCC_W'(vld_d[s]);
    end
  end

  // Pipeline, tag and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= {STAGES{1'b0}};
      occ_q <= {OCC_W{1'b0}};
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= {W{1'b0}};
        tag_q[s]  <= {TAG_W{1'b0}};
      end
    end else begin
      vld_q  <= vld_d;
      occ_q  <= occ_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_q     = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_gf_muls_scl_pipe.sv
// Randomized self-checking bench for gf_muls_scl_pipe against a log-domain GF(4) model.
module tb_gf_muls_scl_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;
  localparam int W      = 2 * LANES;

  logic             clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       in_mode;
  logic [W-1:0]     in_a, in_b, out_q;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [1:0]       occupancy;

  typedef struct {
    logic [W-1:0]     q;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  gf_muls_scl_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_tag(out_tag), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Nonzero elements as powers of Omega: 01=W, 10=W^2, 11=W^3=1; N=W^2.
  function automatic logic [1:0] ref_elem(input logic [1:0] a, input logic [1:0] b, input logic [1:0] m);
    int la, lb, lr;
    bit is_zero;
    la = (a == 2'b01) ? 1 : (a == 2'b10) ? 2 : 0;
    lb = (b == 2'b01) ? 1 : (b == 2'b10) ? 2 : 0;
    case (m)
      2'd0:    begin is_zero = (a == 2'b00) || (b == 2'b00); lr = la + lb;     end
      2'd1:    begin is_zero = (a == 2'b00) || (b == 2'b00); lr = la + lb + 2; end
      2'd2:    begin is_zero = (a == 2'b00);                 lr = 2 * la;      end
      default: begin is_zero = (a == 2'b00);                 lr = 2 * la + 2;  end
    endcase
    if (is_zero) return 2'b00;
    case (lr % 3)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[2*i +: 2] = ref_elem(a[2*i +: 2], b[2*i +: 2], m);
    return r;
  endfunction

  // One clock: sample handshakes mid-cycle, record accepted transactions, advance.
  task automatic step(output bit acc, output bit xfer, output logic [W-1:0] q, output logic [TAG_W-1:0] tg);
    exp_t e;
    #1;
    acc  = (in_valid === 1'b1) && (in_ready === 1'b1);
    xfer = (out_valid === 1'b1) && (out_ready === 1'b1);
    q    = out_q;
    tg   = out_tag;
    if (acc) begin
      e.q   = ref_word(in_a, in_b, in_mode);
      e.tag = in_tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0;
    in_a = '0; in_b = '0; in_tag = '0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (out_q !== 8'h00) begin n_fail++; $display("FAIL reset_out_q: got %h expected 00", out_q); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_spot();
    logic [1:0] sa [5] = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b01};
    logic [1:0] sb [5] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b11};
    logic [1:0] sm [5] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
    logic [1:0] sx [5] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    bit acc, xfer; logic [W-1:0] q; logic [TAG_W-1:0] tg; exp_t e;
    int sent = 0, got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (sent < 5) begin
        in_valid = 1'b1; in_mode = sm[sent]; in_tag = 4'(sent);
        in_a = {6'($urandom), sa[sent]}; in_b = {6'($urandom), sb[sent]};
      end else in_valid = 1'b0;
      step(acc, xfer, q, tg);
      if (acc) sent++;
      if (xfer) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL spot_unexpected: got tag %h expected none", tg); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (q !== e.q || tg !== e.tag) begin n_fail++; $display("FAIL spot_word: got %h/%h expected %h/%h", q, tg, e.q, e.tag); end
          n_checks++; if (q[1:0] !== sx[got]) begin n_fail++; $display("FAIL spot_lane0_%0d: got %b expected %b", got, q[1:0], sx[got]); end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 5) begin n_fail++; $display("FAIL spot_count: got %0d expected 5", got); end
  endtask

  task automatic test_exhaustive();
    bit acc, xfer; logic [W-1:0] q; logic [TAG_W-1:0] tg; exp_t e;
    int sent = 0, got = 0, p;
    for (int c = 0; c < 300 && got < 16; c++) begin
      if (!in_valid && sent < 16 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_mode = 2'(sent / 4); in_tag = 4'($urandom);
        for (int i = 0; i < LANES; i++) begin
          p = (sent % 4) * 4 + i;
          in_a[2*i +: 2] = p[1:0]; in_b[2*i +: 2] = p[3:2];
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      step(acc, xfer, q, tg);
      if (acc) begin in_valid = 1'b0; sent++; end
      if (xfer) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL exh_unexpected: got %h expected none", q); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (q !== e.q || tg !== e.tag) begin n_fail++; $display("FAIL exh_word: got %h/%h expected %h/%h", q, tg, e.q, e.tag); end
        end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (got != 16) begin n_fail++; $display("FAIL exh_count: got %0d expected 16", got); end
  endtask

  task automatic test_back_to_back();
    bit acc, xfer; logic [W-1:0] q; logic [TAG_W-1:0] tg; exp_t e;
    int sent = 0, got = 0, first_acc = -1, last_x = -1;
    out_ready = 1'b1;
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d expected 0", occupancy); end
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (sent < 10) begin
        in_valid = 1'b1; in_tag = 4'(sent); in_mode = 2'($urandom);
        in_a = 8'($urandom); in_b = 8'($urandom);
      end else in_valid = 1'b0;
      step(acc, xfer, q, tg);
      if (acc) begin
        if (first_acc < 0) first_acc = cyc - 1;
        sent++;
      end
      if (xfer) begin
        if (last_x < 0) begin
          n_checks++; if ((cyc - 1) - first_acc != STAGES) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", (cyc - 1) - first_acc, STAGES); end
        end else begin
          n_checks++; if ((cyc - 1) != last_x + 1) begin n_fail++; $display("FAIL b2b_gap: got cycle %0d expected %0d", cyc - 1, last_x + 1); end
        end
        last_x = cyc - 1;
        n_checks++; if (tg !== 4'(got)) begin n_fail++; $display("FAIL b2b_tag: got %h expected %h", tg, 4'(got)); end
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL b2b_unexpected: got %h expected none", q); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (q !== e.q) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", q, e.q); end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 10) begin n_fail++; $display("FAIL b2b_count: got %0d expected 10", got); end
  endtask

  task automatic test_backpressure();
    bit acc, xfer; logic [W-1:0] q, q0; logic [TAG_W-1:0] tg, t0; exp_t e;
    int sent = 0, got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && occupancy != 2'(STAGES); c++) begin
      if (!in_valid) begin
        in_valid = 1'b1; in_tag = 4'($urandom); in_mode = 2'($urandom);
        in_a = 8'($urandom); in_b = 8'($urandom);
      end
      step(acc, xfer, q, tg);
      if (acc) begin in_valid = 1'b0; sent++; end
    end
    if (!in_valid) begin
      in_valid = 1'b1; in_tag = 4'($urandom); in_mode = 2'($urandom);
      in_a = 8'($urandom); in_b = 8'($urandom);
    end
    q0 = out_q; t0 = out_tag;
    for (int c = 0; c < 5; c++) begin
      step(acc, xfer, q, tg);
      n_checks++; if (in_ready !== 1'b0 || acc) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (out_q !== q0 || out_tag !== t0) begin n_fail++; $display("FAIL bp_hold: got %h/%h expected %h/%h", out_q, out_tag, q0, t0); end
      n_checks++; if (occupancy !== 2'(STAGES)) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected %0d", occupancy, STAGES); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (in_valid || exp_q.size() != 0); c++) begin
      step(acc, xfer, q, tg);
      if (acc) begin in_valid = 1'b0; sent++; end
      if (xfer) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL bp_unexpected: got %h expected none", q); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (q !== e.q || tg !== e.tag) begin n_fail++; $display("FAIL bp_drain: got %h/%h expected %h/%h", q, tg, e.q, e.tag); end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != sent || sent != STAGES + 1) begin n_fail++; $display("FAIL bp_count: got %0d/%0d expected %0d", got, sent, STAGES + 1); end
  endtask

  task automatic test_bubbles();
    bit acc, xfer; logic [W-1:0] q; logic [TAG_W-1:0] tg; exp_t e;
    bit iv [12]; bit ov [12];
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 6) && (c % 2 == 0);
      in_tag = 4'($urandom); in_mode = 2'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      step(acc, xfer, q, tg);
      iv[c] = acc; ov[c] = xfer;
      n_checks++; if (occupancy > 2'd2) begin n_fail++; $display("FAIL bub_occupancy: got %0d expected <=2", occupancy); end
      if (xfer && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++; if (q !== e.q || tg !== e.tag) begin n_fail++; $display("FAIL bub_data: got %h/%h expected %h/%h", q, tg, e.q, e.tag); end
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (ov[c] != ((c >= STAGES) ? iv[c-STAGES] : 1'b0)) begin n_fail++; $display("FAIL bub_pattern_%0d: got %b expected %b", c, ov[c], (c >= STAGES) ? iv[c-STAGES] : 1'b0); end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bub_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_midreset();
    bit acc, xfer; logic [W-1:0] q; logic [TAG_W-1:0] tg; exp_t e;
    int acc_c = -1, x_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_tag = 4'($urandom); in_mode = 2'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      step(acc, xfer, q, tg);
    end
    in_valid = 1'b0;
    step(acc, xfer, q, tg);
    n_checks++; if (out_valid !== 1'b1 || occupancy !== 2'd2) begin n_fail++; $display("FAIL mr_inflight: got %b/%0d expected 1/2", out_valid, occupancy); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL mr_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (out_q !== 8'h00 || out_tag !== 4'h0) begin n_fail++; $display("FAIL mr_data: got %h/%h expected 00/0", out_q, out_tag); end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_tag = 4'($urandom); in_mode = 2'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
    step(acc, xfer, q, tg);
    if (acc) acc_c = cyc - 1;
    in_valid = 1'b0;
    for (int c = 0; c < 8 && x_c < 0; c++) begin
      step(acc, xfer, q, tg);
      if (xfer) begin
        x_c = cyc - 1;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_checks++; if (q !== e.q || tg !== e.tag) begin n_fail++; $display("FAIL mr_result: got %h/%h expected %h/%h", q, tg, e.q, e.tag); end
        end
      end
    end
    n_checks++; if (acc_c < 0 || x_c - acc_c != STAGES) begin n_fail++; $display("FAIL mr_latency: got %0d expected %0d", x_c - acc_c, STAGES); end
  endtask

  task automatic test_multilane();
    bit acc, xfer; logic [W-1:0] q; logic [TAG_W-1:0] tg; exp_t e;
    int sent = 0, got = 0;
    for (int c = 0; c < 400 && got < 24; c++) begin
      if (!in_valid && sent < 24 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; in_tag = 4'($urandom); in_mode = 2'(sent % 4 + $urandom_range(0, 1));
        in_a = 8'($urandom); in_b = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc, xfer, q, tg);
      if (acc) begin in_valid = 1'b0; sent++; end
      if (xfer) begin
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL ml_unexpected: got %h expected none", q); end
        else begin
          e = exp_q.pop_front();
          n_checks++; if (q !== e.q || tg !== e.tag) begin n_fail++; $display("FAIL ml_word: got %h/%h expected %h/%h", q, tg, e.q, e.tag); end
        end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (got != 24 || exp_q.size() != 0) begin n_fail++; $display("FAIL ml_count: got %0d expected 24", got); end
  endtask

  initial begin
    test_reset();
    test_spot();
    test_exhaustive();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_midreset();
    test_multilane();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf_muls_scl_pipe.md
# gf_muls_scl_pipe

Pipelined, multi-lane GF(2^2) arithmetic unit in the normal basis [Omega^2, Omega]. Each transaction carries LANES independent 2-bit element pairs and a 2-bit mode that selects multiply, multiply-and-scale-by-N, square, or square-and-scale. Results pass through a STAGES-deep register pipeline with valid/ready backpressure. The unit feeds the GF(2^4) and GF(2^8) tower-field datapaths of the sequential Canright-style S-box variants.

## Interface
- LANES, default 4: number of independent GF(2^2) lanes, 1..16.
- STAGES, default 2: pipeline register depth, 1..4.
- TAG_W, default 4: width of the sideband tag carried alongside data, 1..8.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit accepts the input transaction this cycle.
- in_mode  in  2  0 = MUL, 1 = MUL_SCL, 2 = SQ, 3 = SQ_SCL.
- in_a  in  2*LANES  lane i occupies bits [2i+1:2i]; bit 1 is the Omega^2 coefficient, bit 0 is the Omega coefficient.
- in_b  in  2*LANES  second operand, same layout; ignored for SQ and SQ_SCL.
- in_tag  in  TAG_W  sideband, passed through unmodified.
- out_valid  out  1  result present at the last stage.
- out_ready  in  1  downstream accepts the result.
- out_q  out  2*LANES  per-lane result, same layout as in_a.
- out_tag  out  TAG_W  tag of the transaction on out_q.
- occupancy  out  clog2(STAGES+1)  count of valid stages.

## Operation
- Per-lane arithmetic, with x = (x1,x0):
  - MUL: e = (a1^a0)&(b1^b0); q1 = (a1&b1)^e; q0 = (a0&b0)^e.
  - SCL by N = Omega^2: (x1,x0) -> (x0, x1^x0).
  - SQ: (x1,x0) -> (x0,x1), a bit swap.
  - MUL_SCL = SCL(MUL(a,b)).
  - SQ_SCL = SCL(SQ(a)) = (a1, a0^a1).
- Mode applies to all lanes of a transaction. Lanes never interact.
- Arithmetic is evaluated combinationally on the inputs and captured in stage 0. Stages 1..STAGES-1 shift data, tag and valid.
- Global advance: en = ~vld[STAGES-1] | out_ready.
  - in_ready = en.
  - When en is high, every stage loads from its predecessor, and stage 0 loads {in_valid, result, tag}.
  - Bubbles move along with valid data and are not collapsed.
- Acceptance happens when in_valid & in_ready. A transfer-out happens when out_valid & out_ready.
- out_valid = vld[STAGES-1]. out_q and out_tag are driven directly from last-stage registers.
- occupancy = popcount(vld).
- Reset:
  - All vld bits, data and tag registers clear to 0.
  - out_valid = 0, out_q = 0, out_tag = 0, occupancy = 0, in_ready = 1.
- Reset asserted mid-operation discards all in-flight transactions with no partial output. The first cycle after reset deassertion behaves like an empty pipeline.
- Simultaneous accept and transfer-out in the same cycle is legal; occupancy is unchanged when both occur.
- Stall (out_valid & ~out_ready):
  - All stages hold, and in_ready = 0.
  - out_q and out_tag stay stable until the transfer.
  - Upstream must hold in_valid and its data; the unit drops nothing.
- When the pipeline is full with no stall, throughput is one transaction per cycle.

## Timing
- Latency: a transaction accepted in cycle t appears with out_valid = 1 in cycle t+STAGES, provided no stall occurs in between. Each stalled cycle adds one cycle.
- in_ready is combinational from out_ready and vld[STAGES-1]. There is no combinational path from in_valid or the data inputs to any output.
- Critical path: one AND-XOR level plus a mode mux, into stage 0.

## Structure
- Package gf_canright_pkg holds:
  - mode constants MODE_MUL, MODE_MUL_SCL, MODE_SQ, MODE_SQ_SCL;
  - the 2-bit element type;
  - functions gf2_mul, gf2_scl_n and gf2_sq.
- Sub-module gf_muls_scl_lane: a combinational single-lane unit taking (a, b, mode) and producing q. It is instantiated LANES times by a generate loop.
- The top level holds the pipeline registers, the advance logic and the occupancy popcount.

## Test plan
- Exhaustive arithmetic, LANES=1, STAGES=1: all 16 (a,b) pairs × 4 modes checked against the package functions. Spot checks:
  - a=01, b=01, MUL -> 10.
  - same operands, MUL_SCL -> 01.
  - a=11, b=10, MUL -> 10.
  - a=01, SQ -> 10.
  - a=01, SQ_SCL -> 01.
- Latency and throughput, STAGES=3, out_ready=1: 10 back-to-back transactions with tags 0..9 -> the first out_valid appears 3 cycles after the first accept, then one result per cycle in order, with tags matching.
- Backpressure: out_ready low for 5 cycles while the pipeline is full -> in_ready = 0, out_q and out_tag held, occupancy = STAGES. On release, all results drain in order with none lost or duplicated.
- Bubbles: in_valid toggled 1,0,1,0 -> out_valid reproduces the same pattern STAGES cycles later, and occupancy never exceeds 2 for STAGES=3.
- Mid-operation reset: assert rst with 2 transactions in flight -> out_valid = 0 and occupancy = 0 immediately, asynchronously. After release, a new transaction emerges after exactly STAGES cycles.
- Multi-lane independence, LANES=4: a different mode per transaction and distinct per-lane operands -> each lane matches the package functions, with no cross-lane effect.
